// File: rtl/alu_pkg.sv
// Shared types for the ALU output stage: opcodes, status bit positions and the stored FIFO entry.
// Optional parity storage is enabled by defining ALU_OUT_PARITY_EN.
package alu_pkg;

  localparam int unsigned RESULT_W = 4;
  localparam int unsigned STATUS_W = 4;

  typedef enum logic [1:0] {
    OP_SUB    = 2'd0,
    OP_CMP    = 2'd1,
    OP_SETBIT = 2'd2,
    OP_ZM2U2  = 2'd3
  } op_e;

  localparam int unsigned ST_ZERO    = 0;
  localparam int unsigned ST_NEG     = 1;
  localparam int unsigned ST_EVEN    = 2;
  localparam int unsigned ST_ALLONES = 3;

  typedef struct packed {
`ifdef ALU_OUT_PARITY_EN
    logic                parity;
`endif
    op_e                 op;
    logic [STATUS_W-1:0] status;
    logic [RESULT_W-1:0] result;
  } entry_t;

  // Parity bit that makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [RESULT_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/alu_out_mem.sv
// Entry storage for the ALU output FIFO: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the owning buffer.
module alu_out_mem
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  entry_t                   i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output entry_t                   o_rd_data
);

  entry_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/alu_out_buffer.sv
// FWFT result/status FIFO behind the ALU, with sticky status and sticky drop flags.
// Define ALU_OUT_PARITY_EN to store per-entry result parity and expose o_parity/o_par_err.
module alu_out_buffer
  import alu_pkg::*;
#(
  parameter int unsigned m     = RESULT_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned S     = STATUS_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [m-1:0]             i_result,
  input  logic [S-1:0]             i_status,
  input  logic [1:0]               i_op,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [m-1:0]             o_result,
  output logic [S-1:0]             o_status,
  output logic [1:0]               o_op,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [S-1:0]             o_sticky,
  output logic                     o_drop,
`ifdef ALU_OUT_PARITY_EN
  output logic                     o_parity,
  output logic                     o_par_err,
`endif
  input  logic                     i_clr_sticky
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [S-1:0]  r_sticky;
  logic          r_drop;

  logic   w_push;
  logic   w_pop;
  logic   w_drop;
  entry_t w_wr_data;
  entry_t w_head;

  assign o_ready = (r_count != CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;
  assign w_drop  = i_valid && !o_ready;

  always_comb begin
    w_wr_data        = '0;
    w_wr_data.op     = op_e'(i_op);
    w_wr_data.status = i_status;
    w_wr_data.result = i_result;
`ifdef ALU_OUT_PARITY_EN
    w_wr_data.parity = even_parity(i_result);
`endif
  end

  alu_out_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .i_clk    (i_clk),
    .i_wr_en  (w_push),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(w_wr_data),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(w_head)
  );

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Clear applies before the OR of a same-cycle push; a same-cycle drop beats clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sticky <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push)            r_sticky <= (i_clr_sticky ? '0 : r_sticky) | i_status;
      else if (i_clr_sticky) r_sticky <= '0;
      if (w_drop)            r_drop <= 1'b1;
      else if (i_clr_sticky) r_drop <= 1'b0;
    end
  end

  assign o_result = o_valid ? w_head.result : '0;
  assign o_status = o_valid ? w_head.status : '0;
  assign o_op     = o_valid ? 2'(w_head.op) : 2'b00;
  assign o_count  = r_count;
  assign o_sticky = r_sticky;
  assign o_drop   = r_drop;

`ifdef ALU_OUT_PARITY_EN
  assign o_parity  = o_valid ? w_head.parity : 1'b0;
  assign o_par_err = o_valid && ((^o_result) != o_parity);
`endif

endmodule

// File: tb/tb_alu_out_buffer.sv
// Directed self-checking bench for alu_out_buffer (default build, parity optional via ALU_OUT_PARITY_EN).
module tb_alu_out_buffer;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_result;
  logic [3:0] i_status;
  logic [1:0] i_op;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_result;
  logic [3:0] o_status;
  logic [1:0] o_op;
  logic [2:0] o_count;
  logic [3:0] o_sticky;
  logic       o_drop;
  logic       i_clr_sticky;
`ifdef ALU_OUT_PARITY_EN
  logic       o_parity;
  logic       o_par_err;
`endif

  int total = 0;
  int bad   = 0;

  alu_out_buffer #(.m(4), .DEPTH(4), .S(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_result    (i_result),
    .i_status    (i_status),
    .i_op        (i_op),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_status    (o_status),
    .o_op        (o_op),
    .o_count     (o_count),
    .o_sticky    (o_sticky),
    .o_drop      (o_drop),
`ifdef ALU_OUT_PARITY_EN
    .o_parity    (o_parity),
    .o_par_err   (o_par_err),
`endif
    .i_clr_sticky(i_clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0; i_ready = 1'b0; i_clr_sticky = 1'b0;
    i_result = '0; i_status = '0; i_op = '0;
  endtask

  task automatic push(input logic [3:0] res, input logic [3:0] st, input logic [1:0] op);
    i_valid = 1'b1; i_result = res; i_status = st; i_op = op;
    step();
    i_valid = 1'b0;
  endtask

  task automatic drain_all();
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (o_valid) step();
    end
    i_ready = 1'b0;
    i_clr_sticky = 1'b1; step(); i_clr_sticky = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    total++; if (o_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    total++; if (o_sticky !== 4'b0000) begin bad++; $display("FAIL reset_sticky got=%b exp=0000", o_sticky); end
    total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b exp=0", o_drop); end
    total++; if (o_result !== 4'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", o_result); end
  endtask

  task automatic test_single_push();
    push(4'hA, 4'b0100, 2'(OP_SUB));
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", o_valid); end
    total++; if (o_result !== 4'hA) begin bad++; $display("FAIL single_result got=%h exp=a", o_result); end
    total++; if (o_status !== 4'b0100) begin bad++; $display("FAIL single_status got=%b exp=0100", o_status); end
    total++; if (o_op !== 2'd0) begin bad++; $display("FAIL single_op got=%0d exp=0", o_op); end
    total++; if (o_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", o_count); end
    total++; if (o_sticky !== 4'b0100) begin bad++; $display("FAIL single_sticky got=%b exp=0100", o_sticky); end
`ifdef ALU_OUT_PARITY_EN
    total++; if (o_parity !== 1'b0 || o_par_err !== 1'b0) begin bad++; $display("FAIL single_parity got=%b/%b exp=0/0", o_parity, o_par_err); end
`endif
    i_ready = 1'b1; step(); i_ready = 1'b0;
    total++; if (o_valid !== 1'b0 || o_result !== 4'h0) begin bad++; $display("FAIL single_pop got=%b/%h exp=0/0", o_valid, o_result); end
    drain_all();
  endtask

  task automatic test_full_drop();
    for (int k = 1; k <= 4; k++) push(4'(k), 4'b0000, 2'(OP_CMP));
    total++; if (o_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", o_count); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", o_ready); end
    total++; if (o_op !== 2'd1) begin bad++; $display("FAIL full_op got=%0d exp=1", o_op); end
    push(4'h5, 4'b1000, 2'(OP_CMP));
    total++; if (o_drop !== 1'b1) begin bad++; $display("FAIL drop_flag got=%b exp=1", o_drop); end
    total++; if (o_count !== 3'd4) begin bad++; $display("FAIL drop_count got=%0d exp=4", o_count); end
    total++; if (o_sticky !== 4'b0000) begin bad++; $display("FAIL drop_sticky got=%b exp=0000", o_sticky); end
    // pop while full: push is still refused
    i_ready = 1'b1; i_valid = 1'b1; i_result = 4'h9;
    total++; if (o_result !== 4'h1) begin bad++; $display("FAIL drain_head1 got=%h exp=1", o_result); end
    step(); i_valid = 1'b0;
    total++; if (o_count !== 3'd3) begin bad++; $display("FAIL full_pop_push got=%0d exp=3", o_count); end
    for (int k = 2; k <= 4; k++) begin
      total++; if (o_result !== 4'(k)) begin bad++; $display("FAIL drain_head%0d got=%h exp=%h", k, o_result, 4'(k)); end
      step();
    end
    i_ready = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", o_valid); end
    i_clr_sticky = 1'b1; step(); i_clr_sticky = 1'b0;
    total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL drop_clear got=%b exp=0", o_drop); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q[$];
    push(4'h8, 4'b0000, 2'(OP_SETBIT)); exp_q.push_back(4'h8);
    push(4'h9, 4'b0000, 2'(OP_SETBIT)); exp_q.push_back(4'h9);
    for (int k = 0; k < 6; k++) begin
      total++; if (o_result !== exp_q[0]) begin bad++; $display("FAIL b2b_head%0d got=%h exp=%h", k, o_result, exp_q[0]); end
      i_valid = 1'b1; i_ready = 1'b1; i_result = 4'(10 + k); i_op = 2'(OP_SETBIT); i_status = 4'b0000;
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(4'(10 + k));
      total++; if (o_count !== 3'd2) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=2", k, o_count); end
    end
    i_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (o_result !== exp_q[k]) begin bad++; $display("FAIL b2b_tail%0d got=%h exp=%h", k, o_result, exp_q[k]); end
      step();
    end
    i_ready = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", o_valid); end
    drain_all();
  endtask

  task automatic test_sticky_clr();
    push(4'h2, 4'b0001, 2'(OP_ZM2U2));
    total++; if (o_sticky !== 4'b0001) begin bad++; $display("FAIL sticky_or got=%b exp=0001", o_sticky); end
    push(4'h3, 4'b0010, 2'(OP_ZM2U2));
    total++; if (o_sticky !== 4'b0011) begin bad++; $display("FAIL sticky_or2 got=%b exp=0011", o_sticky); end
    i_clr_sticky = 1'b1; push(4'h4, 4'b1000, 2'(OP_ZM2U2)); i_clr_sticky = 1'b0;
    total++; if (o_sticky !== 4'b1000) begin bad++; $display("FAIL sticky_clr_push got=%b exp=1000", o_sticky); end
    total++; if (o_count !== 3'd3) begin bad++; $display("FAIL sticky_count got=%0d exp=3", o_count); end
    i_clr_sticky = 1'b1; step(); i_clr_sticky = 1'b0;
    total++; if (o_sticky !== 4'b0000) begin bad++; $display("FAIL sticky_clr got=%b exp=0000", o_sticky); end
    total++; if (o_count !== 3'd3 || o_result !== 4'h2) begin bad++; $display("FAIL clr_keeps_fifo got=%0d/%h exp=3/2", o_count, o_result); end
    push(4'h5, 4'b0000, 2'(OP_SUB));
    i_clr_sticky = 1'b1; push(4'h6, 4'b0100, 2'(OP_SUB)); i_clr_sticky = 1'b0;
    total++; if (o_drop !== 1'b1) begin bad++; $display("FAIL drop_beats_clr got=%b exp=1", o_drop); end
    total++; if (o_sticky !== 4'b0000) begin bad++; $display("FAIL drop_no_or got=%b exp=0000", o_sticky); end
    drain_all();
  endtask

  task automatic test_async_reset();
    push(4'h1, 4'b0010, 2'(OP_SUB));
    push(4'h2, 4'b0010, 2'(OP_SUB));
    push(4'h3, 4'b0010, 2'(OP_SUB));
    #2 rst = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", o_valid); end
    total++; if (o_count !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", o_count); end
    total++; if (o_sticky !== 4'b0000) begin bad++; $display("FAIL arst_sticky got=%b exp=0000", o_sticky); end
    total++; if (o_result !== 4'h0) begin bad++; $display("FAIL arst_result got=%h exp=0", o_result); end
    step();
    rst = 1'b0;
    step();
    push(4'h7, 4'b0000, 2'(OP_CMP));
    total++; if (o_valid !== 1'b1 || o_result !== 4'h7) begin bad++; $display("FAIL arst_push got=%b/%h exp=1/7", o_valid, o_result); end
    total++; if (o_count !== 3'd1) begin bad++; $display("FAIL arst_push_count got=%0d exp=1", o_count); end
`ifdef ALU_OUT_PARITY_EN
    total++; if (o_parity !== 1'b1 || o_par_err !== 1'b0) begin bad++; $display("FAIL arst_parity got=%b/%b exp=1/0", o_parity, o_par_err); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_push();
    test_full_drop();
    test_back_to_back();
    test_sticky_clr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_out_buffer.md
Name: alu_out_buffer

Overview:
- Downstream stage of the ALU operation modules (subtract, compare, bit-set, sign-magnitude to U2 converter).
- Captures each produced result/status pair, tagged with its opcode, into a small FWFT FIFO with valid/ready handshakes.
- Maintains sticky status flags and a sticky drop flag for the host/readout stage.

Parameters:
- m, 4, result data width (bits)
- DEPTH, 4, FIFO entries; power of two, >= 2
- S, 4, status width (bit meanings in the package)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_valid  in  1  upstream result valid
- o_ready  out  1  buffer can accept (not full)
- i_result  in  m  ALU result
- i_status  in  S  ALU status
- i_op  in  2  opcode that produced the entry (op_e)
- o_valid  out  1  head entry valid
- i_ready  in  1  downstream accepts head
- o_result  out  m  head result
- o_status  out  S  head status
- o_op  out  2  head opcode
- o_count  out  $clog2(DEPTH)+1  entries stored
- o_sticky  out  S  OR of status of all accepted entries since last clear
- o_drop  out  1  sticky: push attempted while full
- i_clr_sticky  in  1  synchronous clear of o_sticky and o_drop

Behaviour:
- Reset (async, i_rst=1): wr/rd pointers=0, count=0; o_valid=0, o_ready=1, o_count=0, o_sticky=0, o_drop=0; o_result/o_status/o_op=0 while empty. Storage contents need no reset.
- Push: i_valid && o_ready at a rising edge. Writes {i_op, i_status, i_result} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: o_valid && i_ready at a rising edge. rd_ptr increments modulo DEPTH.
- o_ready = (count != DEPTH). It is not pop-aware: when full, no push is accepted even if a pop occurs in the same cycle.
- o_valid = (count != 0). Head fields are driven from storage at rd_ptr (first-word fall-through).
- Outputs forced to 0 when empty.
- Latency: a push into an empty buffer gives o_valid=1 and the head data in the next cycle.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together (0 < count < DEPTH): unchanged, both pointers advance
  - push and pop together at count=0: not possible, because o_valid=0
- Pointers wrap from DEPTH-1 to 0; ordering is strictly FIFO.
- Sticky status:
  - Each accepted push ORs i_status into o_sticky.
  - i_clr_sticky alone sets o_sticky to 0.
  - i_clr_sticky together with a push sets o_sticky to the pushed i_status (clear, then OR).
- Drop:
  - i_valid && !o_ready sets o_drop on the next edge; the data is discarded.
  - i_clr_sticky clears o_drop; when clear and a drop occur together, drop wins (o_drop=1).
- i_clr_sticky does not affect FIFO contents.
- Reset mid-operation: all entries are lost immediately and asynchronously; outputs return to reset values without waiting for a clock.
- Input stability while i_valid && !o_ready is not required; the upstream ALU is combinational.

Optional Feature:
- Macro: ALU_OUT_PARITY_EN
- Defined:
  - Each entry stores an extra bit: even parity of i_result, computed at push.
  - Output port o_parity (1 bit) gives the head's stored parity; 0 when empty or in reset.
  - Output port o_par_err (1 bit, combinational) = o_valid && (^o_result != o_parity).
- Undefined: no parity storage and no o_parity/o_par_err ports.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [1:0] op_e: OP_SUB=0, OP_CMP=1, OP_SETBIT=2, OP_ZM2U2=3
  - status bit index constants: ST_ZERO=0, ST_NEG=1, ST_EVEN=2, ST_ALLONES=3
  - typedef struct packed entry_t {op, status, result}
- One sub-module, alu_out_mem: DEPTH x entry_t register array with one synchronous write port and one asynchronous read port (wr_en, wr_addr, wr_data, rd_addr, rd_data).
- Pointer/count/sticky logic stays in alu_out_buffer.

Test Plan:
- Reset then idle -> o_valid=0, o_ready=1, o_count=0, o_sticky=4'b0000, o_drop=0, o_result=0.
- Push (res=4'hA, st=4'b0100, op=OP_SUB) with i_ready=0 -> next cycle o_valid=1, o_result=4'hA, o_op=0, o_count=1, o_sticky=4'b0100.
- Push 4'h1..4'h4 with i_ready=0 -> o_count=4, o_ready=0; a 5th push of 4'h5 -> o_drop=1 and count stays 4; drain -> heads 1,2,3,4 in order, then o_valid=0.
- At count=2, push and pop in the same cycle for 6 cycles -> o_count stays 2, pointers wrap, data order preserved.
- o_sticky=4'b0001, then i_clr_sticky together with a push of st=4'b1000 -> o_sticky=4'b1000.
- At count=3, assert i_rst between clock edges -> o_valid=0, o_count=0, o_sticky=0 immediately; after release, a push of 4'h7 appears at the head one cycle later.
